// File: rtl/len2beat_split.sv
// len2beat_split: breaks a byte-length request into per-beat byte counts
// for a C_STRB_BIT_NUM-byte stream. One length is accepted at a time.
// ceil(LEN/C_STRB_BIT_NUM) beats are then issued. The final beat is flagged
// with BEAT_LAST_O.
module len2beat_split #(
  parameter int unsigned C_STRB_BIT_NUM = 32,
  parameter int unsigned C_LEN_WIDTH    = 32
) (
  input  logic                   CLK_I,
  input  logic                   RST_I,
  input  logic                   LEN_VALID_I,
  output logic                   LEN_READY_O,
  input  logic [C_LEN_WIDTH-1:0] LEN_I,
  output logic                   BEAT_VALID_O,
  input  logic                   BEAT_READY_I,
  output logic [31:0]            BEAT_NUM_O,
  output logic                   BEAT_LAST_O,
  output logic [C_LEN_WIDTH-1:0] BEAT_IDX_O,
  output logic                   ZERO_LEN_O
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  // Beat size at the width of rem, plus one extra bit so the comparison
  // stays correct when C_LEN_WIDTH is narrow.
  localparam logic [C_LEN_WIDTH:0]   STRB_W = (C_LEN_WIDTH+1)'(C_STRB_BIT_NUM);
  localparam logic [C_LEN_WIDTH-1:0] STEP   = C_LEN_WIDTH'(C_STRB_BIT_NUM);

  state_e                 state_q, state_d;
  logic [C_LEN_WIDTH-1:0] rem_q, rem_d;
  logic [C_LEN_WIDTH-1:0] idx_q, idx_d;
  logic                   zero_q, zero_d;

  logic run_w, gt_w, last_w;

  // Payload is derived only from registered state, so it holds during stalls.
  assign run_w  = (state_q == RUN);
  assign gt_w   = ({1'b0, rem_q} > STRB_W);
  assign last_w = run_w & ~gt_w;

  assign LEN_READY_O  = (state_q == IDLE) & ~RST_I;
  assign BEAT_VALID_O = run_w;
  assign BEAT_LAST_O  = last_w;
  assign BEAT_NUM_O   = run_w ? (gt_w ? 32'(C_STRB_BIT_NUM) : 32'(rem_q)) : 32'd0;
  assign BEAT_IDX_O   = idx_q;
  assign ZERO_LEN_O   = zero_q;

  // Next state: accept a length in IDLE, retire one beat per handshake in RUN.
  // rem is only reduced when it exceeds one beat, so it cannot underflow.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    zero_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (LEN_VALID_I) begin
          if (LEN_I == '0) begin
            zero_d = 1'b1;
          end else begin
            rem_d   = LEN_I;
            idx_d   = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (BEAT_READY_I) begin
          if (last_w) begin
            rem_d   = '0;
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            rem_d = rem_q - STEP;
            idx_d = idx_q + C_LEN_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset. Reset abandons any transfer in flight.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= IDLE;
      rem_q   <= '0;
      idx_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      zero_q  <= zero_d;
    end
  end

endmodule
